// File: rtl/mem_stage_ls_pkg.sv
// Shared definitions for the load/store MEM stage: access sizes, FSM states,
// store lane steering and load extraction helpers.
package mem_stage_ls_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_WAIT,
      ST_HOLD
   } mem_state_e;

   function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_B:    return 4'b0001 << a;
         SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
      case (size)
         SZ_B:    return {4{d[7:0]}};
         SZ_H:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] a,
                                                input logic [1:0] size, input logic sext);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{a, 3'b000} +: 8];
      h = a[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_B:    return {{24{sext & b[7]}}, b};
         SZ_H:    return {{16{sext & h[15]}}, h};
         default: return rdata;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_ls_if.sv
// SRAM-like split request/response data bus (addr_ok accepts a request,
// data_ok returns its response later).
interface mem_stage_ls_if #(parameter int ADDR_W = 32);
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [3:0]        data_wstrb;
   logic [ADDR_W-1:0] data_addr;
   logic [31:0]       data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [31:0]       data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load lane select and zero/sign extension.
module mem_load_align
   import mem_stage_ls_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sext,
   output logic [31:0] result
);
   assign result = load_extract(rdata, addr_lo, size, sext);
endmodule

// File: rtl/mem_stage_ls.sv
// MEM pipeline stage issuing loads/stores on a split addr_ok/data_ok bus,
// buffering responses under WB stall and discarding responses owed to cancelled ops.
module mem_stage_ls
   import mem_stage_ls_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int RF_AW       = 5,
   parameter int MAX_DISCARD = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cancel,
   input  logic              exe_to_mem_valid,
   output logic              mem_allowin,
   output logic              exe_wait_addr,
   input  logic [31:0]       exe_pc,
   input  logic [ADDR_W-1:0] exe_result,
   input  logic              exe_rf_we,
   input  logic [RF_AW-1:0]  exe_rf_waddr,
   input  logic              exe_mem_req,
   input  logic              exe_mem_wr,
   input  logic [1:0]        exe_mem_size,
   input  logic              exe_mem_sext,
   input  logic [31:0]       exe_store_data,
   mem_stage_ls_if.master    bus,
   input  logic              wb_allowin,
   output logic              mem_valid,
   output logic              mem_to_wb_valid,
   output logic [31:0]       mem_pc,
   output logic              mem_rf_we,
   output logic [RF_AW-1:0]  mem_rf_waddr,
   output logic [31:0]       mem_rf_wdata,
   output logic              mem_ale
);
   localparam int CW = $clog2(MAX_DISCARD + 1);
   localparam logic [CW-1:0] DISC_MAX = CW'(MAX_DISCARD);

   typedef struct packed {
      logic [31:0]       pc;
      logic [ADDR_W-1:0] result;
      logic              rf_we;
      logic [RF_AW-1:0]  rf_waddr;
      logic              req;
      logic              wr;
      logic [1:0]        size;
      logic              sext;
      logic              ale;
   } ctl_t;

   mem_state_e    state_q, state_d;
   ctl_t          ctl_q, ctl_d;
   logic          buf_valid_q, buf_valid_d;
   logic [31:0]   buf_q, buf_d;
   logic [CW-1:0] discard_cnt_q, discard_cnt_d;

   logic        ale_x, issue, req_ok, accept, ready_go, data_ok_own, inc, dec;
   logic [31:0] ld_raw, ld_data;

   always_comb begin
      ale_x = exe_mem_req & (((exe_mem_size == SZ_H) & exe_result[0]) |
                             ((exe_mem_size == SZ_W) & (exe_result[1:0] != 2'b00)));
      // a response only belongs to the current instruction once all owed discards drained
      data_ok_own     = bus.data_data_ok & (discard_cnt_q == '0);
      ready_go        = (state_q != ST_WAIT) | data_ok_own | buf_valid_q;
      mem_valid       = (state_q != ST_EMPTY);
      mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
      issue           = exe_to_mem_valid & exe_mem_req & ~ale_x;
      req_ok          = resetn & issue & mem_allowin & ~cancel & (discard_cnt_q < DISC_MAX);
      exe_wait_addr   = issue & ~(req_ok & bus.data_addr_ok);
      accept          = exe_to_mem_valid & mem_allowin & ~exe_wait_addr & ~cancel;
      mem_to_wb_valid = mem_valid & ready_go & ~cancel;
      inc             = cancel & (state_q == ST_WAIT) & ~bus.data_data_ok;
      dec             = bus.data_data_ok & (discard_cnt_q != '0);
   end

   always_comb begin
      bus.data_req   = 1'b0;
      bus.data_wr    = 1'b0;
      bus.data_size  = 2'b00;
      bus.data_wstrb = 4'b0000;
      bus.data_addr  = '0;
      bus.data_wdata = '0;
      if (resetn) begin
         bus.data_req   = req_ok;
         bus.data_wr    = exe_mem_wr;
         bus.data_size  = exe_mem_size;
         bus.data_wstrb = exe_mem_wr ? store_strb(exe_mem_size, exe_result[1:0]) : 4'b0000;
         bus.data_addr  = {exe_result[ADDR_W-1:2], 2'b00};
         bus.data_wdata = store_wdata(exe_mem_size, exe_store_data);
      end
   end

   always_comb begin
      state_d       = state_q;
      ctl_d         = ctl_q;
      buf_valid_d   = buf_valid_q;
      buf_d         = buf_q;
      discard_cnt_d = discard_cnt_q;
      if (cancel) begin
         state_d     = ST_EMPTY;
         buf_valid_d = 1'b0;
      end else if (mem_allowin) begin
         buf_valid_d = 1'b0;
         if (accept) begin
            state_d = issue ? ST_WAIT : ST_HOLD;
            ctl_d   = '{pc: exe_pc, result: exe_result, rf_we: exe_rf_we, rf_waddr: exe_rf_waddr,
                        req: exe_mem_req, wr: exe_mem_wr, size: exe_mem_size,
                        sext: exe_mem_sext, ale: ale_x};
         end else begin
            state_d = ST_EMPTY;
         end
      end else if ((state_q == ST_WAIT) && data_ok_own) begin
         state_d     = ST_HOLD;
         buf_valid_d = 1'b1;
         buf_d       = bus.data_rdata;
      end
      if (inc & ~dec)      discard_cnt_d = discard_cnt_q + CW'(1);
      else if (dec & ~inc) discard_cnt_d = discard_cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_EMPTY;
         ctl_q         <= '0;
         buf_valid_q   <= 1'b0;
         buf_q         <= '0;
         discard_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         ctl_q         <= ctl_d;
         buf_valid_q   <= buf_valid_d;
         buf_q         <= buf_d;
         discard_cnt_q <= discard_cnt_d;
      end
   end

   assign ld_raw = buf_valid_q ? buf_q : bus.data_rdata;

   mem_load_align u_load_align (
      .rdata   (ld_raw),
      .addr_lo (ctl_q.result[1:0]),
      .size    (ctl_q.size),
      .sext    (ctl_q.sext),
      .result  (ld_data)
   );

   assign mem_pc       = ctl_q.pc;
   assign mem_rf_we    = ctl_q.rf_we & ~ctl_q.ale;
   assign mem_rf_waddr = ctl_q.rf_waddr;
   assign mem_ale      = ctl_q.ale;
   assign mem_rf_wdata = (ctl_q.req & ~ctl_q.wr) ? ld_data : 32'(ctl_q.result);

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed bench for mem_stage_ls and the standalone mem_load_align.
module tb_mem_stage_ls;
   logic        clk = 1'b0;
   logic        resetn, cancel, exe_to_mem_valid, exe_rf_we, exe_mem_req, exe_mem_wr, exe_mem_sext;
   logic [31:0] exe_pc, exe_result, exe_store_data;
   logic [4:0]  exe_rf_waddr;
   logic [1:0]  exe_mem_size;
   logic        wb_allowin;
   logic        mem_allowin, exe_wait_addr, mem_valid, mem_to_wb_valid, mem_rf_we, mem_ale;
   logic [31:0] mem_pc, mem_rf_wdata;
   logic [4:0]  mem_rf_waddr;

   logic [31:0] al_rdata, al_res;
   logic [1:0]  al_a, al_sz;
   logic        al_sx;

   int errors = 0;
   int checks = 0;

   mem_stage_ls_if #(.ADDR_W(32)) bus ();

   mem_stage_ls #(.ADDR_W(32), .RF_AW(5), .MAX_DISCARD(3)) dut (
      .clk(clk), .resetn(resetn), .cancel(cancel),
      .exe_to_mem_valid(exe_to_mem_valid), .mem_allowin(mem_allowin), .exe_wait_addr(exe_wait_addr),
      .exe_pc(exe_pc), .exe_result(exe_result), .exe_rf_we(exe_rf_we), .exe_rf_waddr(exe_rf_waddr),
      .exe_mem_req(exe_mem_req), .exe_mem_wr(exe_mem_wr), .exe_mem_size(exe_mem_size),
      .exe_mem_sext(exe_mem_sext), .exe_store_data(exe_store_data), .bus(bus),
      .wb_allowin(wb_allowin), .mem_valid(mem_valid), .mem_to_wb_valid(mem_to_wb_valid),
      .mem_pc(mem_pc), .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
      .mem_rf_wdata(mem_rf_wdata), .mem_ale(mem_ale)
   );

   mem_load_align u_align (.rdata(al_rdata), .addr_lo(al_a), .size(al_sz), .sext(al_sx), .result(al_res));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic exe_idle;
      exe_to_mem_valid = 1'b0; exe_mem_req = 1'b0; exe_mem_wr = 1'b0; exe_rf_we = 1'b0;
   endtask

   task automatic exe_ld(input logic [31:0] pc, input logic [31:0] a, input logic [1:0] sz,
                         input logic sx, input logic [4:0] rd);
      exe_to_mem_valid = 1'b1; exe_pc = pc; exe_result = a; exe_mem_req = 1'b1; exe_mem_wr = 1'b0;
      exe_mem_size = sz; exe_mem_sext = sx; exe_rf_we = 1'b1; exe_rf_waddr = rd;
   endtask

   task automatic exe_st(input logic [31:0] pc, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] d);
      exe_to_mem_valid = 1'b1; exe_pc = pc; exe_result = a; exe_mem_req = 1'b1; exe_mem_wr = 1'b1;
      exe_mem_size = sz; exe_mem_sext = 1'b0; exe_rf_we = 1'b0; exe_rf_waddr = 5'd0; exe_store_data = d;
   endtask

   task automatic test_reset;
      resetn = 1'b0; cancel = 1'b0; wb_allowin = 1'b1; exe_store_data = 32'h0;
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
      exe_st(32'h44, 32'h1000, 2'd2, 32'hCAFEF00D);
      #3;
      checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", bus.data_req); end
      checks++; if (bus.data_wstrb !== 4'h0) begin errors++; $display("FAIL rst_wstrb: got %0h want 0", bus.data_wstrb); end
      checks++; if (bus.data_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %0h want 0", bus.data_addr); end
      tick;
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", mem_valid); end
      checks++; if (mem_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %0h want 0", mem_pc); end
      checks++; if (mem_rf_we !== 1'b0 || mem_rf_waddr !== 5'd0) begin errors++;
         $display("FAIL rst_rf: got we=%0b wa=%0d want 0/0", mem_rf_we, mem_rf_waddr); end
      checks++; if (mem_ale !== 1'b0) begin errors++; $display("FAIL rst_ale: got %0b want 0", mem_ale); end
      checks++; if (dut.discard_cnt_q !== 2'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", dut.discard_cnt_q); end
      exe_idle(); bus.data_addr_ok = 1'b0;
      #1 resetn = 1'b1;
      tick;
   endtask

   task automatic test_ld_w;
      exe_ld(32'h100, 32'h1000, 2'd2, 1'b0, 5'd5); bus.data_addr_ok = 1'b1; #1;
      checks++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h1000) begin errors++;
         $display("FAIL ldw_req: got req=%0b addr=%0h want 1/1000", bus.data_req, bus.data_addr); end
      checks++; if (exe_wait_addr !== 1'b0) begin errors++; $display("FAIL ldw_wait: got %0b want 0", exe_wait_addr); end
      tick; exe_idle(); bus.data_addr_ok = 1'b0; #1;
      checks++; if (mem_valid !== 1'b1 || mem_to_wb_valid !== 1'b0) begin errors++;
         $display("FAIL ldw_c1: got v=%0b tw=%0b want 1/0", mem_valid, mem_to_wb_valid); end
      tick;
      checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL ldw_c2: got %0b want 0", mem_to_wb_valid); end
      tick; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEADBEEF; #1;
      checks++; if (mem_to_wb_valid !== 1'b1 || mem_rf_wdata !== 32'hDEADBEEF) begin errors++;
         $display("FAIL ldw_data: got tw=%0b wd=%0h want 1/deadbeef", mem_to_wb_valid, mem_rf_wdata); end
      checks++; if (mem_rf_we !== 1'b1 || mem_rf_waddr !== 5'd5 || mem_pc !== 32'h100) begin errors++;
         $display("FAIL ldw_rf: got we=%0b wa=%0d pc=%0h want 1/5/100", mem_rf_we, mem_rf_waddr, mem_pc); end
      tick; bus.data_data_ok = 1'b0; #1;
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL ldw_leave: got %0b want 0", mem_valid); end
   endtask

   task automatic test_ld_b;
      logic [31:0] exp [2];
      exp[0] = 32'hFFFFFF80; exp[1] = 32'h00000080;
      for (int i = 0; i < 2; i++) begin
         exe_ld(32'h104, 32'h1003, 2'd0, (i == 0), 5'd3); bus.data_addr_ok = 1'b1; #1;
         checks++; if (bus.data_addr !== 32'h1000 || bus.data_size !== 2'd0) begin errors++;
            $display("FAIL ldb_addr%0d: got %0h/%0d want 1000/0", i, bus.data_addr, bus.data_size); end
         tick; exe_idle(); bus.data_addr_ok = 1'b0;
         bus.data_data_ok = 1'b1; bus.data_rdata = 32'h80FF0011; #1;
         checks++; if (mem_to_wb_valid !== 1'b1 || mem_rf_wdata !== exp[i]) begin errors++;
            $display("FAIL ldb_data%0d: got tw=%0b wd=%0h want 1/%0h", i, mem_to_wb_valid, mem_rf_wdata, exp[i]); end
         tick; bus.data_data_ok = 1'b0;
      end
   endtask

   task automatic test_store;
      exe_st(32'h108, 32'h2002, 2'd1, 32'h1234ABCD); bus.data_addr_ok = 1'b0; #1;
      checks++; if (bus.data_wr !== 1'b1 || bus.data_wstrb !== 4'b1100 || bus.data_wdata !== 32'hABCDABCD) begin errors++;
         $display("FAIL sth_bus: got wr=%0b st=%b wd=%0h want 1/1100/abcdabcd", bus.data_wr, bus.data_wstrb, bus.data_wdata); end
      checks++; if (bus.data_addr !== 32'h2000 || exe_wait_addr !== 1'b1) begin errors++;
         $display("FAIL sth_wait: got addr=%0h wait=%0b want 2000/1", bus.data_addr, exe_wait_addr); end
      exe_st(32'h10C, 32'h2001, 2'd0, 32'h0000005A); bus.data_addr_ok = 1'b1; #1;
      checks++; if (bus.data_wstrb !== 4'b0010 || bus.data_wdata !== 32'h5A5A5A5A) begin errors++;
         $display("FAIL stb_bus: got st=%b wd=%0h want 0010/5a5a5a5a", bus.data_wstrb, bus.data_wdata); end
      tick; exe_idle(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; #1;
      checks++; if (mem_to_wb_valid !== 1'b1 || mem_rf_we !== 1'b0) begin errors++;
         $display("FAIL st_done: got tw=%0b we=%0b want 1/0", mem_to_wb_valid, mem_rf_we); end
      tick; bus.data_data_ok = 1'b0;
   endtask

   task automatic test_ale;
      exe_ld(32'h110, 32'h1001, 2'd2, 1'b0, 5'd6); bus.data_addr_ok = 1'b1; #1;
      checks++; if (bus.data_req !== 1'b0 || exe_wait_addr !== 1'b0 || mem_allowin !== 1'b1) begin errors++;
         $display("FAIL ale_issue: got req=%0b wait=%0b ain=%0b want 0/0/1", bus.data_req, exe_wait_addr, mem_allowin); end
      tick; exe_idle(); bus.data_addr_ok = 1'b0; #1;
      checks++; if (mem_ale !== 1'b1 || mem_rf_we !== 1'b0 || mem_to_wb_valid !== 1'b1) begin errors++;
         $display("FAIL ale_mem: got ale=%0b we=%0b tw=%0b want 1/0/1", mem_ale, mem_rf_we, mem_to_wb_valid); end
      tick;
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL ale_leave: got %0b want 0", mem_valid); end
   endtask

   task automatic test_buffer;
      exe_ld(32'h120, 32'h3002, 2'd1, 1'b1, 5'd8); bus.data_addr_ok = 1'b1;
      tick; exe_idle(); bus.data_addr_ok = 1'b0; wb_allowin = 1'b0;
      bus.data_data_ok = 1'b1; bus.data_rdata = 32'h80017FFF; #1;
      checks++; if (mem_allowin !== 1'b0 || mem_to_wb_valid !== 1'b1) begin errors++;
         $display("FAIL buf_c0: got ain=%0b tw=%0b want 0/1", mem_allowin, mem_to_wb_valid); end
      tick; bus.data_data_ok = 1'b0; bus.data_rdata = 32'hAAAAAAAA; #1;
      checks++; if (mem_rf_wdata !== 32'hFFFF8001 || mem_allowin !== 1'b0) begin errors++;
         $display("FAIL buf_c1: got wd=%0h ain=%0b want ffff8001/0", mem_rf_wdata, mem_allowin); end
      wb_allowin = 1'b1; #1;
      checks++; if (mem_allowin !== 1'b1 || mem_to_wb_valid !== 1'b1 || mem_rf_wdata !== 32'hFFFF8001) begin errors++;
         $display("FAIL buf_rel: got ain=%0b tw=%0b wd=%0h want 1/1/ffff8001", mem_allowin, mem_to_wb_valid, mem_rf_wdata); end
      tick;
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL buf_leave: got %0b want 0", mem_valid); end
   endtask

   task automatic test_cancel_discard;
      exe_ld(32'h130, 32'h4000, 2'd2, 1'b0, 5'd7); bus.data_addr_ok = 1'b1;
      tick; exe_idle(); bus.data_addr_ok = 1'b0; cancel = 1'b1; #1;
      checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL cn_tw: got %0b want 0", mem_to_wb_valid); end
      tick; cancel = 1'b0; #1;
      checks++; if (mem_valid !== 1'b0 || dut.discard_cnt_q !== 2'd1) begin errors++;
         $display("FAIL cn_cnt: got v=%0b cnt=%0d want 0/1", mem_valid, dut.discard_cnt_q); end
      exe_ld(32'h134, 32'h5000, 2'd2, 1'b0, 5'd9); bus.data_addr_ok = 1'b1; #1;
      checks++; if (bus.data_req !== 1'b1) begin errors++; $display("FAIL cn_req: got %0b want 1", bus.data_req); end
      tick; exe_idle(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h11111111; #1;
      checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL cn_drop: got %0b want 0", mem_to_wb_valid); end
      tick; bus.data_rdata = 32'h22222222; #1;
      checks++; if (mem_to_wb_valid !== 1'b1 || mem_rf_wdata !== 32'h22222222 || mem_rf_waddr !== 5'd9) begin errors++;
         $display("FAIL cn_new: got tw=%0b wd=%0h wa=%0d want 1/22222222/9", mem_to_wb_valid, mem_rf_wdata, mem_rf_waddr); end
      tick; bus.data_data_ok = 1'b0;
   endtask

   task automatic test_max_discard;
      for (int i = 0; i < 3; i++) begin
         exe_ld(32'h140, 32'h6000, 2'd2, 1'b0, 5'd10); bus.data_addr_ok = 1'b1;
         tick; exe_idle(); bus.data_addr_ok = 1'b0; cancel = 1'b1;
         tick; cancel = 1'b0;
      end
      #1;
      checks++; if (dut.discard_cnt_q !== 2'd3) begin errors++; $display("FAIL mx_cnt: got %0d want 3", dut.discard_cnt_q); end
      exe_ld(32'h150, 32'h7000, 2'd2, 1'b0, 5'd11); bus.data_addr_ok = 1'b1; #1;
      checks++; if (bus.data_req !== 1'b0 || exe_wait_addr !== 1'b1) begin errors++;
         $display("FAIL mx_block: got req=%0b wait=%0b want 0/1", bus.data_req, exe_wait_addr); end
      tick;
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL mx_noacc: got %0b want 0", mem_valid); end
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
      tick; bus.data_data_ok = 1'b0; #1;
      checks++; if (dut.discard_cnt_q !== 2'd2 || bus.data_req !== 1'b1) begin errors++;
         $display("FAIL mx_drain: got cnt=%0d req=%0b want 2/1", dut.discard_cnt_q, bus.data_req); end
      exe_idle(); bus.data_data_ok = 1'b1;
      tick; tick; bus.data_data_ok = 1'b0; #1;
      checks++; if (dut.discard_cnt_q !== 2'd0) begin errors++; $display("FAIL mx_empty: got %0d want 0", dut.discard_cnt_q); end
   endtask

   task automatic test_align;
      logic [31:0] exp [3];
      logic [1:0]  aa [3];
      logic [1:0]  ss [3];
      logic        xx [3];
      aa[0] = 2'd0; ss[0] = 2'd1; xx[0] = 1'b0; exp[0] = 32'h0000F00D;
      aa[1] = 2'd0; ss[1] = 2'd1; xx[1] = 1'b1; exp[1] = 32'hFFFFF00D;
      aa[2] = 2'd1; ss[2] = 2'd0; xx[2] = 1'b0; exp[2] = 32'h000000F0;
      al_rdata = 32'h1234F00D;
      for (int i = 0; i < 3; i++) begin
         al_a = aa[i]; al_sz = ss[i]; al_sx = xx[i]; #1;
         checks++; if (al_res !== exp[i]) begin errors++;
            $display("FAIL align%0d: got %0h want %0h", i, al_res, exp[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_ld_w();
      test_ld_b();
      test_store();
      test_ale();
      test_buffer();
      test_cancel_discard();
      test_max_discard();
      test_align();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
